// File: rtl/allophone_pkg.sv
// rtl/allophone_pkg.sv - shared widths, FSM states and table-entry layout for the allophone player
package allophone_pkg;
  localparam int CODE_W          = 6;
  localparam int ADDR_W          = 16;
  localparam int LEN_W           = 12;
  localparam int CLK_DIV_DEFAULT = 12500;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOOKUP,
    ST_PLAY,
    ST_FETCH,
    ST_DRAIN
  } state_e;

  typedef struct packed {
    logic [ADDR_W-1:0] start;
    logic [LEN_W-1:0]  len;
    logic              silent;
  } entry_t;
endpackage

// File: rtl/allophone_if.sv
// rtl/allophone_if.sv - code handshake, sample-ROM port and DAC outputs of the allophone player
interface allophone_if;
  import allophone_pkg::*;

  logic [CODE_W-1:0] code;
  logic              code_valid;
  logic              code_ready;
  logic              busy;
  logic [ADDR_W-1:0] rom_addr;
  logic              rom_en;
  logic signed [7:0] rom_data;
  logic signed [7:0] sample;
  logic              hush;

  modport slave (
    input  code, code_valid, rom_data,
    output code_ready, busy, rom_addr, rom_en, sample, hush
  );

  modport master (
    output code, code_valid, rom_data,
    input  code_ready, busy, rom_addr, rom_en, sample, hush
  );
endinterface

// File: rtl/allophone_table.sv
// rtl/allophone_table.sv - combinational allophone code to sample-ROM entry lookup
module allophone_table
  import allophone_pkg::*;
(
  input  logic [CODE_W-1:0] code_i,
  output entry_t            entry_o
);

  // Codes 0-4 are pauses measured in ticks; voiced codes hold the current ROM image layout.
  always_comb begin
    entry_o = '{start: ADDR_W'({code_i, 8'h00}), len: LEN_W'(code_i), silent: 1'b0};
    case (code_i)
      6'd0:    entry_o = '{start: '0, len: LEN_W'(80),   silent: 1'b1};
      6'd1:    entry_o = '{start: '0, len: LEN_W'(240),  silent: 1'b1};
      6'd2:    entry_o = '{start: '0, len: LEN_W'(360),  silent: 1'b1};
      6'd3:    entry_o = '{start: '0, len: LEN_W'(800),  silent: 1'b1};
      6'd4:    entry_o = '{start: '0, len: LEN_W'(1600), silent: 1'b1};
      6'd10:   entry_o = '{start: 16'h0100, len: LEN_W'(3), silent: 1'b0};
      6'd11:   entry_o = '{start: 16'h0200, len: LEN_W'(2), silent: 1'b0};
      6'd12:   entry_o = '{start: 16'h0300, len: LEN_W'(0), silent: 1'b0};
      6'd13:   entry_o = '{start: 16'hFFFE, len: LEN_W'(4), silent: 1'b0};
      default: ;
    endcase
  end

endmodule

// File: rtl/allophone_player.sv
// rtl/allophone_player.sv - plays allophones from a sample ROM into the delta-sigma DAC at a fixed rate
module allophone_player
  import allophone_pkg::*;
#(
  parameter int CLK_DIV = CLK_DIV_DEFAULT
) (
  input  logic        clk,
  input  logic        rst,
  allophone_if.slave  bus
);

  localparam int CNT_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

  state_e            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [CODE_W-1:0] code_q, code_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [LEN_W-1:0]  rem_q, rem_d;
  logic              silent_q, silent_d;
  logic signed [7:0] sample_q, sample_d;
  logic              hush_q, hush_d;

  logic   tick;
  logic   ready;
  logic   xfer;
  logic   rom_en;
  entry_t entry;

  allophone_table u_table (
    .code_i  (code_q),
    .entry_o (entry)
  );

  assign tick  = (cnt_q == CNT_W'(CLK_DIV - 1));
  assign cnt_d = tick ? '0 : cnt_q + 1'b1;
  assign xfer  = bus.code_valid && ready;

  always_comb begin
    state_d  = state_q;
    code_d   = xfer ? bus.code : code_q;
    addr_d   = addr_q;
    rem_d    = rem_q;
    silent_d = silent_q;
    sample_d = sample_q;
    hush_d   = hush_q;
    ready    = (state_q == ST_IDLE) || (state_q == ST_DRAIN);
    rom_en   = 1'b0;
    case (state_q)
      ST_IDLE: if (xfer) state_d = ST_LOOKUP;
      ST_LOOKUP: begin
        addr_d   = entry.start;
        rem_d    = entry.len;
        silent_d = entry.silent;
        if (entry.len == '0) begin
          state_d  = ST_IDLE;
          hush_d   = 1'b1;
          sample_d = '0;
        end else begin
          state_d  = ST_PLAY;
        end
      end
      ST_PLAY: if (tick) begin
        if (silent_q) begin
          sample_d = '0;
          hush_d   = 1'b1;
          rem_d    = rem_q - 1'b1;
          if (rem_q == LEN_W'(1)) state_d = ST_DRAIN;
        end else begin
          rom_en  = 1'b1;
          state_d = ST_FETCH;
        end
      end
      ST_FETCH: begin
        sample_d = bus.rom_data;
        hush_d   = 1'b0;
        addr_d   = addr_q + 1'b1;
        rem_d    = rem_q - 1'b1;
        state_d  = (rem_q == LEN_W'(1)) ? ST_DRAIN : ST_PLAY;
      end
      // A new code beats the end-of-period hush so back-to-back allophones stay gapless.
      ST_DRAIN: begin
        if (xfer) begin
          state_d = ST_LOOKUP;
        end else if (tick) begin
          hush_d   = 1'b1;
          sample_d = '0;
          state_d  = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      cnt_q    <= '0;
      code_q   <= '0;
      addr_q   <= '0;
      rem_q    <= '0;
      silent_q <= 1'b0;
      sample_q <= '0;
      hush_q   <= 1'b1;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      code_q   <= code_d;
      addr_q   <= addr_d;
      rem_q    <= rem_d;
      silent_q <= silent_d;
      sample_q <= sample_d;
      hush_q   <= hush_d;
    end
  end

  assign bus.code_ready = ready;
  assign bus.busy       = (state_q != ST_IDLE);
  assign bus.rom_addr   = addr_q;
  assign bus.rom_en     = rom_en;
  assign bus.sample     = sample_q;
  assign bus.hush       = hush_q;

endmodule

// File: doc/allophone_player.md
Name: allophone_player

Overview:
- Upstream feeder for the delta-sigma speaker DAC.
- Accepts allophone codes over a valid/ready handshake and looks up each code's sample-ROM start address, length and silent flag.
- Streams signed 8-bit samples from an external synchronous sample ROM at a fixed sample rate, and drives hush while idle or during pause allophones.
- Outputs connect directly to the DAC's sample and hush inputs.

Parameters:
- CLK_DIV, 12500, system clocks per sample period (100 MHz / 8 kHz); sims use 4.
- ADDR_W, 16, sample-ROM address width.
- LEN_W, 12, allophone length field width, in samples or ticks.
- CODE_W, 6, allophone code width (64 codes).

Ports:
- clk  in  1  system clock.
- rst  in  1  synchronous active-high reset.
- code  in  CODE_W  allophone code.
- code_valid  in  1  code present.
- code_ready  out  1  block can accept a code.
- busy  out  1  state is not IDLE.
- rom_addr  out  ADDR_W  sample-ROM address (registered).
- rom_en  out  1  sample-ROM read strobe.
- rom_data  in  8  signed sample; valid the cycle after rom_en.
- sample  out  8  signed sample to DAC.
- hush  out  1  silence request to DAC.

Behaviour:
- Decided: one clock, clk; reset port rst is synchronous and active-high.
- Reset values: sample=0, hush=1, code_ready=1, busy=0, rom_en=0, rom_addr=0, tick counter=0, state=IDLE. Reset mid-playback aborts on the next edge, with no final sample.
- Tick: free-running counter 0..CLK_DIV-1. tick=1 in the cycle where counter==CLK_DIV-1. Runs in all states.
- Handshake: transfer occurs when code_valid && code_ready. code_ready=1 only in IDLE and DRAIN. code is latched on transfer. code_valid while not ready is ignored; the source holds it.
- States: IDLE, LOOKUP, PLAY, FETCH, DRAIN.
- IDLE: hush=1, sample=0. Transfer -> LOOKUP.
- LOOKUP (1 cycle): read the table. Load addr=start, rem=len, silent flag.
  - len==0 -> IDLE, and hush=1 is forced on that edge.
  - otherwise -> PLAY.
- PLAY, non-silent: on tick, rom_en=1 for exactly that cycle with rom_addr=addr -> FETCH.
- PLAY, silent: on tick, sample<=0, hush<=1, rem<=rem-1, with no ROM access. When rem reaches 0 -> DRAIN.
- FETCH (1 cycle): sample<=rom_data, hush<=0, addr<=addr+1 mod 2^ADDR_W, rem<=rem-1.
  - rem was 1 -> DRAIN.
  - otherwise -> PLAY.
- Latency: the sample output changes 2 clocks after the tick cycle (tick edge T, visible T+2).
- DRAIN: the final sample is held one full period.
  - Transfer in DRAIN -> LOOKUP, keeping sample/hush unchanged. Playback is gapless: the next sample lands on the next tick.
  - Next tick with no transfer -> hush<=1, sample<=0 -> IDLE.
  - Transfer and tick in the same cycle: the transfer wins and hush stays unchanged.
- Tick arriving during LOOKUP: it is not back-dated. Playback starts at the following tick.
- rom_addr updates only in LOOKUP and FETCH. rom_en is never asserted outside PLAY.

Decomposition:
- Package allophone_pkg holds:
  - CODE_W, ADDR_W, LEN_W constants;
  - state enum;
  - table-entry struct {start[ADDR_W], len[LEN_W], silent};
  - default CLK_DIV.
- Sub-module allophone_table: combinational code -> entry lookup.
  - Codes 0-4 are silent pauses with lengths 80, 240, 360, 800, 1600 ticks.
  - Remaining entries are loaded from an init file.

Test Plan:
- Reset, then idle for 20 cycles -> hush=1, sample=0, code_ready=1, rom_en never asserted.
- Table stub code 10 = {start 0x0100, len 3}, ROM returns addr[7:0]+1, CLK_DIV=4 -> rom_addr sequence 0x100/101/102; sample 0x01, 0x02, 0x03 each held 4 clocks, each update 2 clocks after its tick; then hush=1 one period later.
- Code 10, then code 11 {start 0x0200, len 2} presented during DRAIN -> accepted, no hush pulse between 0x03 and the first 0x0200 sample.
- Silent code 0 (len 80) -> hush=1 for 80 ticks, zero rom_en, then IDLE.
- Code with len 0 -> back to IDLE within 2 cycles; code_ready low only during LOOKUP.
- Reset asserted in FETCH -> next edge gives reset values, state IDLE; a subsequent code plays from its start address.
